pll_lock_reset_seq: RTL and testbench

Reset sequencer downstream of the rPLL. It watches the PLL lock output, qualifies it, holds the PSRAM controller in reset for the device power-up wait, then supervises controller initialisation with timeout and retry. It releases the user-logic reset last. Any loss of lock re-enters the sequence. Sits between the PLL wrapper and the PSRAM controller / user logic, clocked by the PLL `clkout`.

---
 rtl/pll_lock_reset_seq.sv | 166 ++++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// Reset sequencer after the rPLL: qualifies lock, holds PSRAM in reset for
// the power-up wait, supervises init with timeout/retry, then frees user logic.
// Ports: clk, rst (sync, active-high), lock (async), init_done ->
//   psram_rst, user_rst, ready, fault, retry_cnt[3:0], lost_cnt[7:0]
module pll_lock_reset_seq #(
  parameter int unsigned LOCK_FILTER  = 16,
  parameter int unsigned INIT_WAIT    = 12150,
  parameter int unsigned INIT_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned RELEASE_DLY  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock,
  input  logic       init_done,
  output logic       psram_rst,
  output logic       user_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  typedef enum logic [2:0] {
    S_LOCK,
    S_FILTER,
    S_WAIT,
    S_CINIT,
    S_STAGGER,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [23:0] LF_C  = 24'(LOCK_FILTER);
  localparam logic [23:0] IW_M1 = 24'(INIT_WAIT - 1);
  localparam logic [23:0] IT_M1 = 24'(INIT_TIMEOUT - 1);
  localparam logic [23:0] RD_M1 = 24'(RELEASE_DLY - 1);
  localparam logic [23:0] MR_C  = 24'(MAX_RETRY);

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        sync1_q, sync1_d;
  logic        lock_s_q, lock_s_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  lost_q, lost_d;
  logic        psram_rst_q, psram_rst_d;
  logic        user_rst_q, user_rst_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;
  logic        in_seq;
  logic        retry_ok;

  // Lock loss is only tracked once the filter has accepted lock.
  assign in_seq = (state_q == S_WAIT) || (state_q == S_CINIT) ||
                  (state_q == S_STAGGER) || (state_q == S_RUN);

  assign retry_ok = {20'd0, retry_q} < MR_C;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    lost_d   = lost_q;
    sync1_d  = lock;
    lock_s_d = sync1_q;
    if (in_seq && !lock_s_q) begin
      state_d = S_LOCK;
      cnt_d   = '0;
      if (lost_q != 8'hff) lost_d = lost_q + 8'd1;
    end else begin
      case (state_q)
        S_LOCK: begin
          if (lock_s_q) begin
            state_d = S_FILTER;
            cnt_d   = 24'd1;
          end
        end
        S_FILTER: begin
          if (!lock_s_q) begin
            state_d = S_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == LF_C) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        S_WAIT: begin
          if (cnt_q == IW_M1) begin
            state_d = S_CINIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        S_CINIT: begin
          // init_done beats a timeout landing on the same cycle.
          if (init_done) begin
            state_d = S_STAGGER;
            cnt_d   = '0;
          end else if (cnt_q == IT_M1) begin
            cnt_d = '0;
            if (retry_ok) begin
              state_d = S_WAIT;
              if (retry_q != 4'hf) retry_d = retry_q + 4'd1;
            end else begin
              state_d = S_FAULT;
            end
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        S_STAGGER: begin
          if (cnt_q == RD_M1) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        default: ;
      endcase
    end
    // Outputs are decoded from the next state so they register with it.
    psram_rst_d = !((state_d == S_CINIT) || (state_d == S_STAGGER) ||
                    (state_d == S_RUN));
    user_rst_d  = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOCK;
      cnt_q       <= '0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      retry_q     <= '0;
      lost_q      <= '0;
      psram_rst_q <= 1'b1;
      user_rst_q  <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= sync1_d;
      lock_s_q    <= lock_s_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      psram_rst_q <= psram_rst_d;
      user_rst_q  <= user_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign psram_rst = psram_rst_q;
  assign user_rst  = user_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: vector table, corner sequences,
// then random stimulus against a deadline-based reference model.
module tb_pll_lock_reset_seq;

  localparam int LF = 4;
  localparam int IW = 10;
  localparam int IT = 20;
  localparam int MR = 2;
  localparam int RD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic       init_done = 1'b0;
  logic       psram_rst;
  logic       user_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pll_lock_reset_seq #(
    .LOCK_FILTER (LF),
    .INIT_WAIT   (IW),
    .INIT_TIMEOUT(IT),
    .MAX_RETRY   (MR),
    .RELEASE_DLY (RD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .lock     (lock),
    .init_done(init_done),
    .psram_rst(psram_rst),
    .user_rst (user_rst),
    .ready    (ready),
    .fault    (fault),
    .retry_cnt(retry_cnt),
    .lost_cnt (lost_cnt)
  );

  task automatic chk(string nm, logic [7:0] act,
                     logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic p, logic u,
                         logic r, logic f,
                         logic [3:0] rc, logic [7:0] lc);
    chk({tag, ".psram_rst"}, {7'd0, psram_rst}, {7'd0, p});
    chk({tag, ".user_rst"}, {7'd0, user_rst}, {7'd0, u});
    chk({tag, ".ready"}, {7'd0, ready}, {7'd0, r});
    chk({tag, ".fault"}, {7'd0, fault}, {7'd0, f});
    chk({tag, ".retry_cnt"}, {4'd0, retry_cnt}, {4'd0, rc});
    chk({tag, ".lost_cnt"}, lost_cnt, lc);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Two reset cycles, then lock driven high; the last edge is "edge 0".
  task automatic start_seq();
    rst = 1'b1;
    lock = 1'b0;
    init_done = 1'b0;
    tick(2);
    rst = 1'b0;
    lock = 1'b1;
  endtask

  // Reference model: phases with absolute deadlines (edge numbers).
  localparam int P_LOCK = 0;
  localparam int P_FILT = 1;
  localparam int P_WAIT = 2;
  localparam int P_CINIT = 3;
  localparam int P_STAG = 4;
  localparam int P_RUN = 5;
  localparam int P_FAULT = 6;

  int   now = 0;
  int   ph = P_LOCK;
  int   dl = 0;
  int   m_retry = 0;
  int   m_lost = 0;
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic chk_en = 1'b0;

  always @(posedge clk) begin
    logic ls;
    now++;
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = lock;
    if (rst) begin
      ph = P_LOCK;
      m_retry = 0;
      m_lost = 0;
      m_s1 = 1'b0;
      m_s2 = 1'b0;
    end else if (!ls && ph >= P_WAIT && ph <= P_RUN) begin
      ph = P_LOCK;
      if (m_lost < 255) m_lost++;
    end else begin
      case (ph)
        P_LOCK:
          if (ls) begin
            ph = P_FILT;
            dl = now + LF;
          end
        P_FILT:
          if (!ls) ph = P_LOCK;
          else if (now == dl) begin
            ph = P_WAIT;
            dl = now + IW;
          end
        P_WAIT:
          if (now == dl) begin
            ph = P_CINIT;
            dl = now + IT;
          end
        P_CINIT:
          if (init_done) begin
            ph = P_STAG;
            dl = now + RD;
          end else if (now == dl) begin
            if (m_retry < MR) begin
              if (m_retry < 15) m_retry++;
              ph = P_WAIT;
              dl = now + IW;
            end else begin
              ph = P_FAULT;
            end
          end
        P_STAG:
          if (now == dl) ph = P_RUN;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk_all("rand",
        !(ph == P_CINIT || ph == P_STAG || ph == P_RUN),
        ph != P_RUN, ph == P_RUN, ph == P_FAULT,
        4'(m_retry), 8'(m_lost));
    end
  end

  typedef struct {
    logic       rst;
    logic       lock;
    logic       idn;
    int         n;
    logic       p;
    logic       u;
    logic       r;
    logic       f;
    logic [3:0] rc;
    logic [7:0] lc;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Nominal, then lock loss in RUN and a full replay.
    tbl[0]  = '{1, 0, 0, 2,  1, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 16, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 1,  0, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 5,  0, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 3,  0, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 1,  0, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 1,  0, 0, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 1,  0, 0, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 1,  1, 1, 0, 0, 0, 1};
    tbl[9]  = '{0, 1, 0, 16, 1, 1, 0, 0, 0, 1};
    tbl[10] = '{0, 1, 0, 1,  0, 1, 0, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 5,  0, 1, 0, 0, 0, 1};
    tbl[12] = '{0, 1, 1, 3,  0, 1, 0, 0, 0, 1};
    tbl[13] = '{0, 1, 1, 1,  0, 0, 1, 0, 0, 1};

    tick(1);
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      lock = tbl[i].lock;
      init_done = tbl[i].idn;
      tick(tbl[i].n);
      chk_all($sformatf("vec%0d", i), tbl[i].p, tbl[i].u,
              tbl[i].r, tbl[i].f, tbl[i].rc, tbl[i].lc);
    end

    // Filter glitch: lock low for one cycle while filtering.
    start_seq();
    tick(4);
    lock = 1'b0;
    tick(1);
    lock = 1'b1;
    tick(16);
    chk_all("glitch@21", 1, 1, 0, 0, 0, 0);
    tick(1);
    chk_all("glitch@22", 0, 1, 0, 0, 0, 0);

    // Init timeout: two retries, then FAULT.
    start_seq();
    tick(36);
    chk_all("tmo@36", 0, 1, 0, 0, 0, 0);
    tick(1);
    chk_all("tmo@37", 1, 1, 0, 0, 1, 0);
    tick(30);
    chk_all("tmo@67", 1, 1, 0, 0, 2, 0);
    tick(29);
    chk_all("tmo@96", 0, 1, 0, 0, 2, 0);
    tick(1);
    chk_all("tmo@97", 1, 1, 0, 1, 2, 0);
    for (int i = 0; i < 20; i++) begin
      lock = i[1];
      tick(1);
    end
    chk_all("fault_hold", 1, 1, 0, 1, 2, 0);
    rst = 1'b1;
    tick(1);
    chk_all("fault_rst", 1, 1, 0, 0, 0, 0);

    // init_done on the timeout cycle wins.
    start_seq();
    tick(36);
    init_done = 1'b1;
    tick(1);
    chk_all("sim_id@37", 0, 1, 0, 0, 0, 0);
    tick(3);
    chk_all("sim_id@40", 0, 0, 1, 0, 0, 0);

    // Lock loss on the timeout cycle wins.
    start_seq();
    tick(34);
    lock = 1'b0;
    tick(2);
    chk_all("sim_ll@36", 0, 1, 0, 0, 0, 0);
    tick(1);
    chk_all("sim_ll@37", 1, 1, 0, 0, 0, 1);

    // Reset in WAIT with counter at 5, then a clean restart.
    start_seq();
    tick(12);
    rst = 1'b1;
    tick(1);
    chk_all("rstw", 1, 1, 0, 0, 0, 0);
    rst = 1'b0;
    tick(16);
    chk_all("rstw@29", 1, 1, 0, 0, 0, 0);
    tick(1);
    chk_all("rstw@30", 0, 1, 0, 0, 0, 0);

    // Random stimulus against the reference model.
    rst = 1'b1;
    lock = 1'b0;
    init_done = 1'b0;
    tick(1);
    chk_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (lock) begin
        if ($urandom_range(0, 79) == 0) lock = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        lock = 1'b1;
      end
      init_done = ($urandom_range(0, 13) == 0);
      tick(1);
    end
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
